// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states, frame
// classification, column strobes and the (column, row) -> key code map.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    PRESSED
  } state_e;

  typedef enum logic [1:0] {
    EMPTY,
    SINGLE,
    MULTI
  } frame_e;

  localparam logic [3:0] COL0 = 4'b1110;
  localparam logic [3:0] COL1 = 4'b1101;
  localparam logic [3:0] COL2 = 4'b1011;
  localparam logic [3:0] COL3 = 4'b0111;

  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_C    = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;

  // Number of active-low rows in a sample (0..4).
  function automatic logic [2:0] count_low(input logic [3:0] rows_n);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      n = n + {2'b00, ~rows_n[i]};
    end
    return n;
  endfunction

  // Only meaningful when exactly one row of rows_n is low.
  function automatic logic [3:0] key_decode(input logic [3:0] cols, input logic [3:0] rows_n);
    logic [1:0] r;
    logic [3:0] code;
    case (rows_n)
      4'b1110: r = 2'd0;
      4'b1101: r = 2'd1;
      4'b1011: r = 2'd2;
      default: r = 2'd3;
    endcase
    code = 4'd0;
    case (cols)
      COL0: begin
        case (r)
          2'd0:    code = 4'd1;
          2'd1:    code = 4'd4;
          2'd2:    code = 4'd7;
          default: code = KEY_STAR;
        endcase
      end
      COL1: begin
        case (r)
          2'd0:    code = 4'd2;
          2'd1:    code = 4'd5;
          2'd2:    code = 4'd8;
          default: code = 4'd0;
        endcase
      end
      COL2: begin
        case (r)
          2'd0:    code = 4'd3;
          2'd1:    code = 4'd6;
          2'd2:    code = 4'd9;
          default: code = KEY_HASH;
        endcase
      end
      default: code = KEY_A + {2'b00, r};
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_scan_timer.sv
// Column dwell counter and one-cold column rotation; flags the sample cycle
// of each column and the sample that closes a four-column frame.
module keypad_scan_timer
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] cols,
  output logic       sample,
  output logic       frame_end
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

  logic [DW-1:0] dwell_q, dwell_d;
  logic [3:0]    cols_q, cols_d;

  always_comb begin
    sample    = (dwell_q == DWELL_LAST);
    frame_end = sample && (cols_q == COL3);
    dwell_d   = sample ? '0 : dwell_q + DW'(1);
    cols_d    = sample ? {cols_q[2:0], cols_q[3]} : cols_q;
    cols      = cols_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dwell_q <= '0;
      cols_q  <= COL0;
    end else begin
      dwell_q <= dwell_d;
      cols_q  <= cols_d;
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad controller: synchronizes rows, classifies each scanned frame and
// debounces a single key into press/release pulses and a held level.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       key_release
);

  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_SCANS);

  logic [3:0]       rows_meta_q, rows_sync_q;
  logic             sample, frame_end;
  logic [1:0]       acc_cnt_q, acc_cnt_d;
  logic [3:0]       acc_code_q, acc_code_d;
  state_e           state_q, state_d;
  logic [3:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, rcnt_q, rcnt_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;
  logic             key_release_q, key_release_d;

  logic [2:0] low_cnt, sum_cnt;
  logic [1:0] base_cnt, frame_cnt;
  logic [3:0] frame_code;
  frame_e     frame_res;

  keypad_scan_timer #(.SCAN_DIV(SCAN_DIV)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .cols      (cols),
    .sample    (sample),
    .frame_end (frame_end)
  );

  // Low-row count saturates at 2, which is all it takes to call a frame MULTI.
  always_comb begin
    low_cnt    = count_low(rows_sync_q);
    base_cnt   = (cols == COL0) ? 2'd0 : acc_cnt_q;
    sum_cnt    = {1'b0, base_cnt} + low_cnt;
    frame_cnt  = (sum_cnt >= 3'd2) ? 2'd2 : sum_cnt[1:0];
    frame_code = (low_cnt == 3'd1) ? key_decode(cols, rows_sync_q) : acc_code_q;
    acc_cnt_d  = sample ? frame_cnt : acc_cnt_q;
    acc_code_d = sample ? frame_code : acc_code_q;
    case (frame_cnt)
      2'd0:    frame_res = EMPTY;
      2'd1:    frame_res = SINGLE;
      default: frame_res = MULTI;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    cand_d        = cand_q;
    cnt_d         = cnt_q;
    rcnt_d        = rcnt_q;
    key_code_d    = key_code_q;
    key_valid_d   = 1'b0;
    key_held_d    = key_held_q;
    key_release_d = 1'b0;
    if (frame_end) begin
      case (state_q)
        IDLE: begin
          if (frame_res == SINGLE) begin
            if (DEBOUNCE_SCANS == 1) begin
              key_code_d  = frame_code;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              rcnt_d      = '0;
              state_d     = PRESSED;
            end else begin
              cand_d  = frame_code;
              cnt_d   = CNT_W'(1);
              state_d = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (frame_res == SINGLE) begin
            if (frame_code == cand_q) begin
              if (cnt_q + CNT_W'(1) == DB_LAST) begin
                key_code_d  = frame_code;
                key_valid_d = 1'b1;
                key_held_d  = 1'b1;
                cnt_d       = '0;
                rcnt_d      = '0;
                state_d     = PRESSED;
              end else begin
                cnt_d = cnt_q + CNT_W'(1);
              end
            end else begin
              cand_d = frame_code;
              cnt_d  = CNT_W'(1);
            end
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
        PRESSED: begin
          // Any activity, even a different key or a chord, restarts release debounce.
          if (frame_res == EMPTY) begin
            if (rcnt_q + CNT_W'(1) == DB_LAST) begin
              key_release_d = 1'b1;
              key_held_d    = 1'b0;
              rcnt_d        = '0;
              state_d       = IDLE;
            end else begin
              rcnt_d = rcnt_q + CNT_W'(1);
            end
          end else begin
            rcnt_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rows_meta_q   <= 4'hF;
      rows_sync_q   <= 4'hF;
      acc_cnt_q     <= '0;
      acc_code_q    <= '0;
      state_q       <= IDLE;
      cand_q        <= '0;
      cnt_q         <= '0;
      rcnt_q        <= '0;
      key_code_q    <= '0;
      key_valid_q   <= 1'b0;
      key_held_q    <= 1'b0;
      key_release_q <= 1'b0;
    end else begin
      rows_meta_q   <= rows;
      rows_sync_q   <= rows_meta_q;
      acc_cnt_q     <= acc_cnt_d;
      acc_code_q    <= acc_code_d;
      state_q       <= state_d;
      cand_q        <= cand_d;
      cnt_q         <= cnt_d;
      rcnt_q        <= rcnt_d;
      key_code_q    <= key_code_d;
      key_valid_q   <= key_valid_d;
      key_held_q    <= key_held_d;
      key_release_q <= key_release_d;
    end
  end

  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;
  assign key_held    = key_held_q;
  assign key_release = key_release_q;

endmodule
